// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (configurable data/parity/stop) feeding a first-word-fall-through FIFO.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_DIV    = 50,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             RXD,
  input  logic             RD_EN,
  output logic [7:0]       RD_DATA,
  output logic             RD_VALID,
  output logic [FIFO_AW:0] FIFO_COUNT,
  output logic             OVERRUN,
  output logic             FRAME_ERR,
  output logic             PARITY_ERR,
  input  logic             ERR_CLR
);

  localparam int               CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    CNT_HALF  = CW'(CLK_DIV / 2 - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_t;

  logic                 rx_meta_q, rxs_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_flag_q, par_flag_d;
  logic                 frame_flag_q, frame_flag_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 push;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 ovr_q, ovr_d;

  logic                 cnt_last, cnt_half, par_exp, frame_now;
  logic                 full, pop, push_ok, ovr_set;
  logic [7:0]           push_data;

  // Two-flop synchronizer; the line idles high so both flops reset to 1.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rxs_q     <= rx_meta_q;
    end
  end

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign cnt_half  = (cnt_q == CNT_HALF);
  assign par_exp   = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
  assign frame_now = frame_flag_q | ~rxs_q;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      par_flag_q   <= 1'b0;
      frame_flag_q <= 1'b0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      par_flag_q   <= par_flag_d;
      frame_flag_q <= frame_flag_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    par_flag_d   = par_flag_q;
    frame_flag_d = frame_flag_q;
    ferr_d       = 1'b0;
    perr_d       = 1'b0;
    push         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_half) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_DATA;
            bit_idx_d    = '0;
            stop_idx_d   = 1'b0;
            par_flag_d   = 1'b0;
            frame_flag_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting right leaves it at bit 0.
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PAR: begin
        if (cnt_last) begin
          cnt_d      = '0;
          par_flag_d = (rxs_q != par_exp);
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            if (frame_now) begin
              ferr_d  = 1'b1;
              state_d = S_BRK;
            end else if (par_flag_q) begin
              perr_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              push    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            frame_flag_d = frame_now;
            stop_idx_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BRK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push_data = 8'(shift_q);
  assign full      = (count_q == FULL_CNT);
  assign pop       = RD_EN && (count_q != '0);
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign ovr_set   = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + (FIFO_AW + 1)'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - (FIFO_AW + 1)'(1);
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (ERR_CLR) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign RD_VALID   = (count_q != '0);
  assign RD_DATA    = RD_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign FIFO_COUNT = count_q;
  assign OVERRUN    = ovr_q;
  assign FRAME_ERR  = ferr_q;
  assign PARITY_ERR = perr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (8N1 and 7E2 instances, FIFO depth 4).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int DIV   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rxd_a, rxd_b, rd_en_a, rd_en_b, clr_a, clr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b, ovr_a, ovr_b, ferr_a, ferr_b, perr_a, perr_b;
  logic [2:0] cnt_a, cnt_b;

  uart_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) u_a (
    .CLK(clk), .RST_X(rst_n), .RXD(rxd_a), .RD_EN(rd_en_a), .RD_DATA(rd_data_a),
    .RD_VALID(rd_valid_a), .FIFO_COUNT(cnt_a), .OVERRUN(ovr_a), .FRAME_ERR(ferr_a),
    .PARITY_ERR(perr_a), .ERR_CLR(clr_a));

  uart_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) u_b (
    .CLK(clk), .RST_X(rst_n), .RXD(rxd_b), .RD_EN(rd_en_b), .RD_DATA(rd_data_b),
    .RD_VALID(rd_valid_b), .FIFO_COUNT(cnt_b), .OVERRUN(ovr_b), .FRAME_ERR(ferr_b),
    .PARITY_ERR(perr_b), .ERR_CLR(clr_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int exp_ferr_a = 0, exp_perr_a = 0, exp_ferr_b = 0, exp_perr_b = 0;
  int seen_ferr_a = 0, seen_perr_a = 0, seen_ferr_b = 0, seen_perr_b = 0;
  logic exp_ovr_a = 1'b0;
  bit auto_a = 1'b0, auto_b = 1'b0;
  int pop_at_a = -1;
  logic [2:0] prev_cnt_a = '0;
  int last_push_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Consumers: random reads when auto is set, plus one-shot reads at a chosen cycle.
  initial begin
    rd_en_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_en_a = (auto_a && ($urandom_range(0, 3) != 0)) || (cyc == pop_at_a);
    end
  end
  initial begin
    rd_en_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_en_b = auto_b && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every DUT pop is compared against the scoreboard head; error pulses are counted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en_a && rd_valid_a) begin
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_pop: actual=0x%02h required=no byte", rd_data_a);
        end else begin
          check("a_data", 32'(rd_data_a), 32'(exp_a.pop_front()));
        end
      end
      if (rd_en_b && rd_valid_b) begin
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_pop: actual=0x%02h required=no byte", rd_data_b);
        end else begin
          check("b_data", 32'(rd_data_b), 32'(exp_b.pop_front()));
        end
      end
      if (ferr_a) seen_ferr_a++;
      if (perr_a) seen_perr_a++;
      if (ferr_b) seen_ferr_b++;
      if (perr_b) seen_perr_b++;
    end
  end

  always @(negedge clk) begin
    prev_cnt_a <= cnt_a;
    if (cnt_a > prev_cnt_a) last_push_a <= cyc;
  end

  // Reference model: frame outcome from the stop/parity rules and FIFO occupancy.
  task automatic model_a(input logic [7:0] d, input bit stop_ok, input bit pop_same);
    if (!stop_ok) exp_ferr_a++;
    else if (exp_a.size() < DEPTH || pop_same) exp_a.push_back(d);
    else exp_ovr_a = 1'b1;
  endtask

  task automatic model_b(input logic [6:0] d, input bit par_ok, input bit stop_ok);
    if (!stop_ok) exp_ferr_b++;
    else if (!par_ok) exp_perr_b++;
    else exp_b.push_back({1'b0, d});
  endtask

  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
    return {6'd0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [6:0] d, input logic pbit,
                                          input logic s1, input logic s2);
    return {5'd0, s2, s1, pbit, d, 1'b0};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rxd(input int dev, input logic v);
    if (dev == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  task automatic send(input int dev, input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      set_rxd(dev, bits[i]);
      settle(DIV);
    end
  endtask

  task automatic wait_valid_a(input int max);
    int k = 0;
    while (!rd_valid_a && k < max) begin
      settle(1);
      k++;
    end
    check("a_wait_valid", 32'(rd_valid_a), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_valid"}, 32'(rd_valid_a), 32'd0);
    check({tag, "_count"}, 32'(cnt_a), 32'd0);
    check({tag, "_data"}, 32'(rd_data_a), 32'd0);
    check({tag, "_ovr"}, 32'(ovr_a), 32'd0);
    check({tag, "_ferr"}, 32'(ferr_a), 32'd0);
    check({tag, "_perr"}, 32'(perr_a), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [6:0] d7;
    bit bad, pbad;
    int g, sel, s4, s5, off;
    logic s1, s2;

    rst_n = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    settle(3);
    check_reset_a("rst");
    rst_n = 1'b1;
    settle(4);

    // Single byte, then a one-cycle read empties the FIFO.
    model_a(8'hA5, 1'b1, 1'b0);
    send(0, frame_a(8'hA5, 1'b1), 10);
    wait_valid_a(20);
    check("a5_data", 32'(rd_data_a), 32'hA5);
    check("a5_count", 32'(cnt_a), 32'd1);
    pop_at_a = cyc + 1;
    settle(3);
    check("a5_valid_after_pop", 32'(rd_valid_a), 32'd0);
    check("a5_count_after_pop", 32'(cnt_a), 32'd0);

    // Short low glitch, plus a read while empty.
    rxd_a = 1'b0; settle(3); rxd_a = 1'b1;
    pop_at_a = cyc + 1;
    settle(40);
    check("glitch_count", 32'(cnt_a), 32'd0);
    check("glitch_ferr", 32'(seen_ferr_a), 32'(exp_ferr_a));
    check("glitch_perr", 32'(seen_perr_a), 32'd0);

    // Stop bit low with the line held low afterwards: one frame error, then recovery.
    model_a(8'h00, 1'b0, 1'b0);
    send(0, frame_a(8'h00, 1'b0), 10);
    settle(40);
    check("brk_ferr", 32'(seen_ferr_a), 32'(exp_ferr_a));
    check("brk_count", 32'(cnt_a), 32'd0);
    rxd_a = 1'b1;
    settle(2 * DIV);
    model_a(8'h3C, 1'b1, 1'b0);
    send(0, frame_a(8'h3C, 1'b1), 10);
    wait_valid_a(20);
    check("brk_3c_data", 32'(rd_data_a), 32'h3C);
    pop_at_a = cyc + 1;
    settle(3);
    check("brk_3c_count", 32'(cnt_a), 32'd0);

    // Overrun: five bytes into a four-deep FIFO with no reads.
    for (int i = 1; i <= 5; i++) begin
      model_a(8'(i), 1'b1, 1'b0);
      send(0, frame_a(8'(i), 1'b1), 10);
      settle(2);
    end
    settle(10);
    check("ovr_count", 32'(cnt_a), 32'd4);
    check("ovr_flag", 32'(ovr_a), 32'(exp_ovr_a));
    auto_a = 1'b1; settle(40); auto_a = 1'b0; settle(2);
    check("ovr_drained", 32'(exp_a.size()), 32'd0);
    check("ovr_sticky", 32'(ovr_a), 32'd1);
    clr_a = 1'b1; settle(1); clr_a = 1'b0;
    exp_ovr_a = 1'b0;
    check("ovr_cleared", 32'(ovr_a), 32'(exp_ovr_a));

    // Full FIFO with a pop landing on the push cycle of the fifth byte.
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      model_a(d, 1'b1, 1'b0);
      send(0, frame_a(d, 1'b1), 10);
      settle(2);
    end
    d = 8'($urandom);
    s4 = cyc;
    model_a(d, 1'b1, 1'b0);
    send(0, frame_a(d, 1'b1), 10);
    settle(4);
    off = last_push_a - s4;
    check("full_count", 32'(cnt_a), 32'd4);
    s5 = cyc;
    pop_at_a = s5 + off - 1;
    model_a(8'h05, 1'b1, 1'b1);
    send(0, frame_a(8'h05, 1'b1), 10);
    settle(10);
    check("fullpop_ovr", 32'(ovr_a), 32'd0);
    check("fullpop_count", 32'(cnt_a), 32'd4);
    auto_a = 1'b1; settle(40);
    check("fullpop_drained", 32'(exp_a.size()), 32'd0);

    // Random 8N1 traffic with occasional framing errors.
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      model_a(d, !bad, 1'b0);
      send(0, frame_a(d, !bad), 10);
      if (bad) begin
        settle($urandom_range(1, 20));
        rxd_a = 1'b1;
        settle(2 * DIV + $urandom_range(0, 5));
      end else begin
        g = $urandom_range(0, 3);
        if (g > 0) settle(g);
      end
    end
    settle(40);
    check("rnda_ferr", 32'(seen_ferr_a), 32'(exp_ferr_a));
    check("rnda_perr", 32'(seen_perr_a), 32'd0);
    check("rnda_drained", 32'(exp_a.size()), 32'd0);
    check("rnda_count", 32'(cnt_a), 32'd0);
    check("rnda_ovr", 32'(ovr_a), 32'(exp_ovr_a));

    // 7E2: 0x41 with correct then wrong parity.
    auto_b = 1'b1;
    d7 = 7'h41;
    model_b(d7, 1'b1, 1'b1);
    send(1, frame_b(d7, ^d7, 1'b1, 1'b1), 11);
    settle(4);
    model_b(d7, 1'b0, 1'b1);
    send(1, frame_b(d7, ~(^d7), 1'b1, 1'b1), 11);
    settle(30);
    check("b41_perr", 32'(seen_perr_b), 32'(exp_perr_b));
    check("b41_drained", 32'(exp_b.size()), 32'd0);
    check("b41_count", 32'(cnt_b), 32'd0);

    // Random 7E2 traffic with parity and stop-bit corruption.
    for (int n = 0; n < 20; n++) begin
      d7 = 7'($urandom_range(0, 127));
      pbad = ($urandom_range(0, 4) == 0);
      bad = ($urandom_range(0, 7) == 0);
      s1 = 1'b1; s2 = 1'b1;
      if (bad) begin
        sel = $urandom_range(0, 2);
        if (sel != 1) s1 = 1'b0;
        if (sel != 0) s2 = 1'b0;
      end
      model_b(d7, !pbad, !bad);
      send(1, frame_b(d7, pbad ? ~(^d7) : ^d7, s1, s2), 11);
      rxd_b = 1'b1;
      if (bad) settle(2 * DIV + $urandom_range(0, 5));
      else begin
        g = $urandom_range(0, 3);
        if (g > 0) settle(g);
      end
    end
    settle(40);
    check("rndb_perr", 32'(seen_perr_b), 32'(exp_perr_b));
    check("rndb_ferr", 32'(seen_ferr_b), 32'(exp_ferr_b));
    check("rndb_drained", 32'(exp_b.size()), 32'd0);

    // Asynchronous reset mid-frame with a byte still held in the FIFO.
    auto_a = 1'b0;
    settle(4);
    model_a(8'h77, 1'b1, 1'b0);
    send(0, frame_a(8'h77, 1'b1), 10);
    settle(6);
    check("pre_rst_count", 32'(cnt_a), 32'd1);
    rxd_a = 1'b0;
    settle(3 * DIV);
    #3 rst_n = 1'b0;
    #1 check_reset_a("midrst");
    exp_a.delete();
    rxd_a = 1'b1;
    @(posedge clk); #1;
    settle(2);
    rst_n = 1'b1;
    settle(4);
    model_a(8'h5A, 1'b1, 1'b0);
    send(0, frame_a(8'h5A, 1'b1), 10);
    wait_valid_a(20);
    check("post_rst_data", 32'(rd_data_a), 32'h5A);
    auto_a = 1'b1;
    settle(30);
    check("post_rst_drained", 32'(exp_a.size()), 32'd0);
    check("post_rst_count", 32'(cnt_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a built-in receive FIFO. It is the next generation of the fixed 8N1 deserializer used by the program loader and keyboard path.
- Adds configurable data width, parity and stop bits.
- Adds start-bit validation and framing/parity error detection.
- Buffers bytes in a first-word-fall-through FIFO with overrun flagging, so the consumer need not accept every byte on the cycle it arrives.

Parameters:
CLK_DIV, 50, CLK cycles per bit (f/baud); must be >= 4.
DATA_BITS, 8, data bits per frame; legal values 5..8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
FIFO_DEPTH, 16, FIFO entries; power of 2, >= 2.
FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
CLK  in  1  system clock.
RST_X  in  1  asynchronous, active-low reset.
RXD  in  1  serial input, asynchronous to CLK, idle high.
RD_EN  in  1  pop the FIFO head; ignored when the FIFO is empty.
RD_DATA  out  8  FIFO head; bits above DATA_BITS-1 are 0; valid only while RD_VALID=1.
RD_VALID  out  1  FIFO not empty.
FIFO_COUNT  out  FIFO_AW+1  number of entries held, 0..FIFO_DEPTH.
OVERRUN  out  1  sticky: a good byte was dropped because the FIFO was full.
FRAME_ERR  out  1  one-cycle pulse: a stop bit was sampled low.
PARITY_ERR  out  1  one-cycle pulse: parity mismatch.
ERR_CLR  in  1  clears OVERRUN.

Behaviour:
- Reset (asynchronous, RST_X=0), effective immediately:
  - Synchronizer flops = 1, FSM = IDLE, counters = 0, FIFO pointers = 0.
  - Outputs: RD_VALID=0, FIFO_COUNT=0, RD_DATA=0, OVERRUN=0, FRAME_ERR=0, PARITY_ERR=0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Input sync: RXD passes through 2 flops; rxs is the second flop. All sampling uses rxs, giving 2 cycles of latency.
- Bit counter: cnt counts CLK_DIV cycles per bit. Samples are taken at cnt == CLK_DIV-1, and cnt reloads to 0 on each sample.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
- IDLE:
  - On rxs==0: go to START, cnt=0.
- START:
  - Wait CLK_DIV/2 cycles (integer division), then sample rxs.
  - rxs=1 is a glitch: return to IDLE, no error reported.
  - rxs=0: go to DATA, cnt=0, bit index=0.
- DATA:
  - Sample every CLK_DIV cycles, LSB first, into shift register bits [DATA_BITS-1:0].
  - After DATA_BITS samples: go to PAR if PARITY!=0, else STOP.
- PAR:
  - Sample one bit. Expected value: odd → XOR(data)^1; even → XOR(data).
  - Record any mismatch in a flag; go to STOP.
- STOP:
  - Sample STOP_BITS bits; any stop bit sampled 0 sets a frame flag.
  - At the last stop sample (cycle T), the frame is resolved:
    - Frame flag set: FRAME_ERR=1 at T+1, byte discarded, go to BRK. Frame error takes priority over parity; PARITY_ERR is not pulsed.
    - Else parity flag set: PARITY_ERR=1 at T+1, byte discarded, go to IDLE.
    - Else: push the byte (visible on RD_VALID/FIFO_COUNT at T+1), go to IDLE.
- BRK:
  - Stay until rxs==1, then go to IDLE. This prevents a held-low line (break) from generating repeated frames.
- Error pulses are exactly 1 cycle wide.
- FIFO behaviour:
  - Circular buffer with FIFO_AW-bit pointers that wrap from FIFO_DEPTH-1 to 0.
  - RD_DATA is combinational from the head entry (first-word fall-through).
  - Pop: RD_EN && RD_VALID advances the read pointer.
  - Push when not full: write and advance the write pointer.
  - Push when full with a simultaneous pop: accepted, count unchanged.
  - Push when full without a pop: byte dropped, OVERRUN=1 at T+1.
  - RD_EN while empty has no effect.
  - FIFO_COUNT changes by +1, -1, or 0 (push and pop together).
- OVERRUN clearing:
  - ERR_CLR=1 clears OVERRUN next cycle.
  - If an overrun occurs in the same cycle as ERR_CLR, set wins.
- Back-to-back frames: the FSM is in IDLE at T+1 and accepts a start edge immediately. No idle gap is required beyond the stop bit(s).

Test Plan:
- CLK_DIV=8, 8N1: send 0xA5 → at T+1 RD_VALID=1, RD_DATA=0xA5, FIFO_COUNT=1; RD_EN for 1 cycle → RD_VALID=0, FIFO_COUNT=0.
- RXD low pulse of 3 cycles then high (CLK_DIV=8) → FSM returns to IDLE, no error pulse, FIFO_COUNT stays 0.
- PARITY=2, DATA_BITS=7: send 0x41 with parity bit 0 → byte pushed as 0x41; resend with parity bit 1 → PARITY_ERR pulses once, FIFO_COUNT unchanged.
- Stop bit driven 0 (data 0x00, line then held low 40 cycles) → exactly one FRAME_ERR pulse, no push; FSM waits in BRK; after RXD rises, send 0x3C → 0x3C received.
- FIFO_DEPTH=4: send 5 bytes 0x01..0x05 with no reads → FIFO_COUNT=4, OVERRUN=1; reads return 0x01..0x04; ERR_CLR → OVERRUN=0.
- FIFO full; pulse RD_EN in the cycle the 5th byte pushes → no overrun, FIFO_COUNT stays 4, last entry 0x05. Separately, assert RST_X=0 mid-frame → all outputs at reset values at once; after release, a full 0x5A frame is received correctly.
